// File: rtl/sent_pkg.sv
// Shared types and constants for the SENT slow-channel message scheduler.
// Frame counts are per serial message; the counter is wide enough for both.
package sent_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LOAD,
    SEND,
    DONE
  } state_t;

  localparam int FRAMES_SHORT = 16;
  localparam int FRAMES_ENH   = 18;
  localparam int CNT_W        = 5;

endpackage

// File: rtl/sent_tx_msg_sched_if.sv
// Requester-side bundle: per-slot pending flag, ID, data field and ack.
// The scheduler is the slave; requesters (or the bench) drive the master side.
interface sent_tx_msg_sched_if #(
  parameter int NUM_SLOTS = 4
);

  logic [NUM_SLOTS-1:0]    slot_valid_i;
  logic [NUM_SLOTS*8-1:0]  slot_id_i;
  logic [NUM_SLOTS*16-1:0] slot_data_i;
  logic [NUM_SLOTS-1:0]    slot_ack_o;

  modport master (
    output slot_valid_i,
    output slot_id_i,
    output slot_data_i,
    input  slot_ack_o
  );

  modport slave (
    input  slot_valid_i,
    input  slot_id_i,
    input  slot_data_i,
    output slot_ack_o
  );

endinterface

// File: rtl/sent_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
// Produces a one-hot grant, its encoded index and an any-request flag.
module sent_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last,
  output logic [N-1:0] gnt,
  output logic [2:0]   gnt_idx,
  output logic         any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int o = 1; o <= N; o++) begin
      for (int k = 0; k < N; k++) begin
        if (!any && req[k] &&
            k == (int'(last) + o) % N) begin
          any     = 1'b1;
          gnt[k]  = 1'b1;
          gnt_idx = 3'(k);
        end
      end
    end
  end

endmodule

// File: rtl/sent_tx_msg_sched.sv
// Slow-channel message scheduler: grants one slot at a time and holds its
// ID/data stable for a whole serial message, counted in transmitter frames.
module sent_tx_msg_sched #(
  parameter int NUM_SLOTS    = 4,
  parameter int FRAMES_SHORT = sent_pkg::FRAMES_SHORT,
  parameter int FRAMES_ENH   = sent_pkg::FRAMES_ENH
) (
  input  logic                 clk_tx,
  input  logic                 reset_n_tx,
  input  logic                 run_i,
  input  logic                 channel_format_i,
  sent_tx_msg_sched_if.slave   slots,
  input  logic                 frame_tick_i,
  output logic                 enable_o,
  output logic [7:0]           id_o,
  output logic [15:0]          data_bit_field_o,
  output logic                 format_o,
  output logic                 busy_o,
  output logic [2:0]           cur_slot_o
);

  import sent_pkg::*;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_inc;
  logic [CNT_W-1:0]     n_frames;
  logic                 last_tick;
  logic [2:0]           last_grant;
  logic [NUM_SLOTS-1:0] cur_oh;

  logic [NUM_SLOTS-1:0] gnt;
  logic [2:0]           gnt_idx;
  logic                 any_req;
  logic                 go;

  logic [7:0]           sel_id;
  logic [15:0]          sel_data;

  sent_rr_arbiter #(
    .N (NUM_SLOTS)
  ) u_arb (
    .req     (slots.slot_valid_i),
    .last    (last_grant),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  assign go        = run_i && any_req;
  assign n_frames  = format_o ? CNT_W'(FRAMES_ENH)
                              : CNT_W'(FRAMES_SHORT);
  assign cnt_inc   = cnt + 1'b1;
  assign last_tick = frame_tick_i && (cnt_inc == n_frames);

  // Granted slot's fields, selected by the registered one-hot grant.
  always_comb begin
    sel_id   = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (cur_oh[k]) begin
        sel_id   = slots.slot_id_i[k*8 +: 8];
        sel_data = slots.slot_data_i[k*16 +: 16];
      end
    end
  end

  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (go) state_nxt = ARB;
      ARB:  state_nxt = any_req ? LOAD : IDLE;
      LOAD: state_nxt = SEND;
      SEND: if (last_tick) state_nxt = DONE;
      DONE: state_nxt = go ? ARB : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o           = (state != IDLE);
    slots.slot_ack_o = '0;
    if (state == DONE) slots.slot_ack_o = cur_oh;
  end

  // enable_o stays high across DONE->ARB->LOAD so back-to-back messages
  // never restart the transmitter; it only drops on the way to IDLE.
  always_ff @(posedge clk_tx or negedge reset_n_tx) begin
    if (!reset_n_tx) begin
      cur_slot_o       <= '0;
      cur_oh           <= '0;
      last_grant       <= 3'(NUM_SLOTS - 1);
      cnt              <= '0;
      enable_o         <= 1'b0;
      id_o             <= '0;
      data_bit_field_o <= '0;
      format_o         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: enable_o <= 1'b0;
        ARB: begin
          if (any_req) begin
            cur_slot_o <= gnt_idx;
            cur_oh     <= gnt;
            last_grant <= gnt_idx;
          end else begin
            enable_o   <= 1'b0;
          end
        end
        LOAD: begin
          id_o             <= sel_id;
          data_bit_field_o <= sel_data;
          format_o         <= channel_format_i;
          enable_o         <= 1'b1;
          cnt              <= '0;
        end
        SEND: if (frame_tick_i) cnt <= cnt_inc;
        DONE: if (!go) enable_o <= 1'b0;
        default: enable_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sent_tx_msg_sched.sv
// Directed bench for the slow-channel scheduler: latency, round-robin order,
// message length per format, run/format/reset corner cases.
module tb_sent_tx_msg_sched;

  localparam int NS = 4;

  logic        clk_tx = 1'b0;
  logic        reset_n_tx;
  logic        run_i;
  logic        channel_format_i;
  logic        frame_tick_i;
  logic        enable_o;
  logic [7:0]  id_o;
  logic [15:0] data_bit_field_o;
  logic        format_o;
  logic        busy_o;
  logic [2:0]  cur_slot_o;

  sent_tx_msg_sched_if #(.NUM_SLOTS(NS)) slots ();

  sent_tx_msg_sched #(.NUM_SLOTS(NS)) dut (
    .clk_tx           (clk_tx),
    .reset_n_tx       (reset_n_tx),
    .run_i            (run_i),
    .channel_format_i (channel_format_i),
    .slots            (slots),
    .frame_tick_i     (frame_tick_i),
    .enable_o         (enable_o),
    .id_o             (id_o),
    .data_bit_field_o (data_bit_field_o),
    .format_o         (format_o),
    .busy_o           (busy_o),
    .cur_slot_o       (cur_slot_o)
  );

  always #5 clk_tx = ~clk_tx;

  int checks   = 0;
  int failures = 0;
  int ack_cycles = 0;
  int en_drops   = 0;
  logic mon_en = 1'b0;

  always @(negedge clk_tx) begin
    if (|slots.slot_ack_o) ack_cycles++;
    if (mon_en && !enable_o) en_drops++;
  end

  logic [7:0]  exp_id  [NS] = '{8'h10, 8'h11, 8'h05, 8'h13};
  logic [15:0] exp_dat [NS] = '{16'h1000, 16'h1111, 16'h00A3, 16'h1333};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_tx);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick_i = 1'b1;
      @(posedge clk_tx);
      #1;
      frame_tick_i = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    reset_n_tx = 1'b0;
    step(1);
    reset_n_tx = 1'b1;
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_en"},   enable_o, 0);
    check({tag, "_id"},   id_o, 0);
    check({tag, "_data"}, data_bit_field_o, 0);
    check({tag, "_fmt"},  format_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_slot"}, cur_slot_o, 0);
    check({tag, "_ack"},  slots.slot_ack_o, 0);
  endtask

  int a0;
  int e0;
  int s;

  initial begin
    reset_n_tx       = 1'b0;
    run_i            = 1'b0;
    channel_format_i = 1'b0;
    frame_tick_i     = 1'b0;
    slots.slot_valid_i = '0;
    for (int k = 0; k < NS; k++) begin
      slots.slot_id_i[k*8 +: 8]    = exp_id[k];
      slots.slot_data_i[k*16 +: 16] = exp_dat[k];
    end

    #12;
    check_zero_outs("rst");
    @(posedge clk_tx);
    #1;
    reset_n_tx = 1'b1;

    // Single slot 2, short format.
    slots.slot_valid_i = 4'b0100;
    run_i = 1'b1;
    step(1);
    step(1);
    check("t1_grant", cur_slot_o, 2);
    check("t1_en_k1", enable_o, 0);
    step(1);
    check("t1_en", enable_o, 1);
    check("t1_id", id_o, 8'h05);
    check("t1_data", data_bit_field_o, 16'h00A3);
    check("t1_busy", busy_o, 1);
    a0 = ack_cycles;
    ticks(8);
    check("t1_id_hold", id_o, 8'h05);
    check("t1_data_hold", data_bit_field_o, 16'h00A3);
    ticks(7);
    check("t1_ack_early", slots.slot_ack_o, 0);
    ticks(1);
    check("t1_ack", slots.slot_ack_o, 4'b0100);
    slots.slot_valid_i = 4'b0000;
    step(1);
    check("t1_ack_off", slots.slot_ack_o, 0);
    check("t1_en_off", enable_o, 0);
    check("t1_idle", busy_o, 0);
    check("t1_ack_len", ack_cycles - a0, 1);

    // All slots, enhanced format, back-to-back.
    pulse_reset();
    channel_format_i = 1'b1;
    slots.slot_valid_i = 4'b1111;
    step(3);
    mon_en = 1'b1;
    e0 = en_drops;
    for (int m = 0; m < 5; m++) begin
      s = m % NS;
      check("t2_grant", cur_slot_o, s);
      check("t2_id", id_o, exp_id[s]);
      check("t2_data", data_bit_field_o, exp_dat[s]);
      check("t2_fmt", format_o, 1);
      ticks(17);
      check("t2_ack_early", slots.slot_ack_o, 0);
      ticks(1);
      check("t2_ack", slots.slot_ack_o, 1 << s);
      if (m < 4) step(3);
    end
    run_i = 1'b0;
    slots.slot_valid_i = 4'b0000;
    step(1);
    mon_en = 1'b0;
    check("t2_en_drops", en_drops - e0, 0);
    check("t2_idle", busy_o, 0);
    channel_format_i = 1'b0;

    // run_i falls mid-message.
    slots.slot_valid_i = 4'b0010;
    run_i = 1'b1;
    step(3);
    check("t3_grant", cur_slot_o, 1);
    ticks(5);
    run_i = 1'b0;
    ticks(10);
    check("t3_ack_early", slots.slot_ack_o, 0);
    check("t3_busy", busy_o, 1);
    ticks(1);
    check("t3_ack", slots.slot_ack_o, 4'b0010);
    step(1);
    check("t3_idle", busy_o, 0);
    check("t3_en_off", enable_o, 0);
    slots.slot_valid_i = 4'b0000;

    // Format toggled mid-message.
    slots.slot_valid_i = 4'b0001;
    run_i = 1'b1;
    step(3);
    check("t4_grant", cur_slot_o, 0);
    ticks(3);
    channel_format_i = 1'b1;
    ticks(12);
    check("t4_ack_early", slots.slot_ack_o, 0);
    check("t4_fmt_held", format_o, 0);
    ticks(1);
    check("t4_ack", slots.slot_ack_o, 4'b0001);
    slots.slot_valid_i = 4'b0000;
    channel_format_i = 1'b0;
    step(1);
    check("t4_idle", busy_o, 0);

    // Reset mid-message.
    slots.slot_valid_i = 4'b1010;
    step(3);
    check("t5_grant", cur_slot_o, 1);
    ticks(8);
    a0 = ack_cycles;
    #2;
    reset_n_tx = 1'b0;
    #1;
    check_zero_outs("t5_async");
    step(2);
    check("t5_no_ack", ack_cycles - a0, 0);
    reset_n_tx = 1'b1;
    step(2);
    check("t5_regrant", cur_slot_o, 1);
    check("t5_busy", busy_o, 1);
    step(1);
    check("t5_id", id_o, exp_id[1]);
    run_i = 1'b0;
    slots.slot_valid_i = 4'b0000;
    pulse_reset();

    // Ticks during ARB/LOAD ignored; continuous ticks in SEND.
    slots.slot_valid_i = 4'b1000;
    run_i = 1'b1;
    frame_tick_i = 1'b1;
    step(3);
    check("t6_grant", cur_slot_o, 3);
    check("t6_send", busy_o, 1);
    step(15);
    check("t6_ack_early", slots.slot_ack_o, 0);
    step(1);
    check("t6_ack", slots.slot_ack_o, 4'b1000);
    frame_tick_i = 1'b0;
    slots.slot_valid_i = 4'b0000;
    run_i = 1'b0;
    step(1);
    check("t6_idle", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
